// File: rtl/rvtest_pkg.sv
// Shared types and constants for the riscv-tests campaign sequencer.
// Holds the FSM state encoding, the tohost decode constants and the width helpers.
package rvtest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CORE_RES,
    RUN,
    RECORD,
    DONE
  } state_t;

  // A tohost store terminates the test when bit 0 is set; the value 1 means pass.
  localparam logic [31:0] PASS_CODE = 32'd1;
  localparam int          TERM_BIT  = 0;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rvtest_img_loader.sv
// Copies one test image from the image ROM into main RAM, one word per cycle.
// Absorbs the 1-cycle ROM read latency so each RAM write lands one cycle after its address.
module rvtest_img_loader
  import rvtest_pkg::*;
#(
  parameter int TEST_COUNT = 38,
  parameter int IMG_WORDS  = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  go,
  input  logic [idx_w(TEST_COUNT)-1:0]          idx,
  output logic                                  done,
  output logic [idx_w(TEST_COUNT*IMG_WORDS)-1:0] rom_addr,
  input  logic [31:0]                           rom_data,
  output logic                                  ram_we,
  output logic [idx_w(IMG_WORDS)-1:0]           ram_addr,
  output logic [31:0]                           ram_wdata
);

  localparam int AW = idx_w(TEST_COUNT * IMG_WORDS);
  localparam int WW = idx_w(IMG_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(IMG_WORDS - 1);

  logic          issue;
  logic [WW-1:0] word;

  // go is seen in the cycle before LOAD so the first address is already on rom_addr in LOAD cycle 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue    <= 1'b0;
      word     <= '0;
      rom_addr <= '0;
      ram_we   <= 1'b0;
    end else begin
      ram_we <= issue;
      if (go) begin
        issue    <= 1'b1;
        word     <= '0;
        rom_addr <= AW'(idx) * AW'(IMG_WORDS);
      end else if (issue) begin
        if (word == LAST_WORD) begin
          issue <= 1'b0;
        end else begin
          word     <= word + WW'(1);
          rom_addr <= rom_addr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ram_addr <= word;
    end
  end

  assign ram_wdata = rom_data;
  assign done      = ram_we && (ram_addr == LAST_WORD);

endmodule

// File: rtl/rvtest_sequencer.sv
// Runs a campaign of riscv-tests images: load, reset core, run until tohost or timeout, record.
// The tohost snoop and the per-test timeout counter live here; the image copy is delegated.
module rvtest_sequencer
  import rvtest_pkg::*;
#(
  parameter int          TEST_COUNT      = 38,
  parameter int          IMG_WORDS       = 1024,
  parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES  = 100000,
  parameter int          CORE_RES_CYCLES = 4
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_res,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  core_res,
  output logic [idx_w(TEST_COUNT*IMG_WORDS)-1:0] rom_addr,
  input  logic [31:0]                           rom_data,
  output logic                                  ram_we,
  output logic [idx_w(IMG_WORDS)-1:0]           ram_addr,
  output logic [31:0]                           ram_wdata,
  input  logic                                  dmem_we,
  input  logic [31:0]                           dmem_addr,
  input  logic [31:0]                           dmem_wdata,
  output logic [cnt_w(TEST_COUNT)-1:0]          pass_cnt,
  output logic [cnt_w(TEST_COUNT)-1:0]          fail_cnt,
  output logic [cnt_w(TEST_COUNT)-1:0]          tmo_cnt,
  output logic [idx_w(TEST_COUNT)-1:0]          first_fail,
  output logic                                  first_fail_vld,
  output logic [30:0]                           first_fail_code
);

  localparam int CW = cnt_w(TEST_COUNT);
  localparam int IW = idx_w(TEST_COUNT);
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  localparam int RW = idx_w(CORE_RES_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(TEST_COUNT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RES_LAST = RW'(CORE_RES_CYCLES - 1);

  state_t        state;
  logic [IW-1:0] test_idx;
  logic [TW-1:0] run_cyc;
  logic [RW-1:0] res_cyc;

  logic          campaign_go;
  logic          load_go;
  logic          load_done;
  logic [IW-1:0] load_idx;
  logic          term;
  logic          term_pass;

  assign campaign_go = start && ((state == IDLE) || (state == DONE));
  assign load_go     = campaign_go || ((state == RECORD) && (test_idx != LAST_IDX));
  assign load_idx    = campaign_go ? '0 : test_idx + IW'(1);

  // Only a tohost store with the terminate bit ends a test; other tohost writes are progress noise.
  assign term      = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[TERM_BIT];
  assign term_pass = (dmem_wdata == PASS_CODE);

  rvtest_img_loader #(
    .TEST_COUNT (TEST_COUNT),
    .IMG_WORDS  (IMG_WORDS)
  ) u_loader (
    .clk       (sys_clk),
    .rst       (sys_res),
    .go        (load_go),
    .idx       (load_idx),
    .done      (load_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata)
  );

  always_ff @(posedge sys_clk or posedge sys_res) begin
    if (sys_res) begin
      state           <= IDLE;
      core_res        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      test_idx        <= '0;
      run_cyc         <= '0;
      res_cyc         <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      tmo_cnt         <= '0;
      first_fail      <= '0;
      first_fail_vld  <= 1'b0;
      first_fail_code <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= LOAD;
            busy            <= 1'b1;
            done            <= 1'b0;
            test_idx        <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            tmo_cnt         <= '0;
            first_fail      <= '0;
            first_fail_vld  <= 1'b0;
            first_fail_code <= '0;
          end
        end
        LOAD: begin
          if (load_done) begin
            state   <= CORE_RES;
            res_cyc <= '0;
          end
        end
        CORE_RES: begin
          if (res_cyc == RES_LAST) begin
            state    <= RUN;
            core_res <= 1'b0;
            run_cyc  <= '0;
          end else begin
            res_cyc <= res_cyc + RW'(1);
          end
        end
        RUN: begin
          // A terminating store beats a timeout landing on the same cycle.
          if (term) begin
            if (term_pass) begin
              pass_cnt <= pass_cnt + CW'(1);
            end else begin
              fail_cnt <= fail_cnt + CW'(1);
              if (!first_fail_vld) begin
                first_fail      <= test_idx;
                first_fail_code <= dmem_wdata[31:1];
                first_fail_vld  <= 1'b1;
              end
            end
            state    <= RECORD;
            core_res <= 1'b1;
          end else if (run_cyc == TMO_LAST) begin
            tmo_cnt  <= tmo_cnt + CW'(1);
            state    <= RECORD;
            core_res <= 1'b1;
          end else begin
            run_cyc <= run_cyc + TW'(1);
          end
        end
        RECORD: begin
          if (test_idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            test_idx <= test_idx + IW'(1);
            state    <= LOAD;
          end
        end
        default: begin
          state    <= IDLE;
          core_res <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
